// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - instruction field positions and opcode constants
//   - forwarding mux select encodings
//   - hazard FSM state encoding
//   - small decode helpers (field extract, writer / reader classification)
package pipeline_pkg;

  localparam int INSTR_W = 20;

  localparam int OP_HI = 19;
  localparam int OP_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 12;
  localparam int RS_HI = 11;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  function automatic logic [3:0] op_of(input logic [INSTR_W-1:0] i);
    return i[OP_HI:OP_LO];
  endfunction

  function automatic logic [3:0] rd_of(input logic [INSTR_W-1:0] i);
    return i[RD_HI:RD_LO];
  endfunction

  function automatic logic [3:0] rs_of(input logic [INSTR_W-1:0] i);
    return i[RS_HI:RS_LO];
  endfunction

  function automatic logic [3:0] rt_of(input logic [INSTR_W-1:0] i);
    return i[RT_HI:RT_LO];
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return !(op inside {OP_NOP, OP_LD, OP_ST, OP_BEQ, OP_JMP});
  endfunction

  // r0 is hard-wired, so an rd of 0 never produces a hazard
  function automatic logic is_writer(input logic [INSTR_W-1:0] i);
    return !(op_of(i) inside {OP_ST, OP_BEQ, OP_JMP, OP_NOP}) && (rd_of(i) != 4'd0);
  endfunction

  function automatic logic reads_rs(input logic [INSTR_W-1:0] i);
    return !(op_of(i) inside {OP_NOP, OP_JMP});
  endfunction

  function automatic logic reads_rt(input logic [INSTR_W-1:0] i);
    return is_alu(op_of(i)) || (op_of(i) inside {OP_ST, OP_BEQ});
  endfunction

endpackage

// File: rtl/forward_select.sv
// Forwarding source select for one ALU operand.
//   i_src_reg   : source register read by the instruction in EX
//   i_mem_wr    : EX/MEM instruction writes a register (rd != 0)
//   i_mem_is_ld : EX/MEM instruction is a load (data not ready yet)
//   i_mem_rd    : EX/MEM destination register
//   i_wb_wr     : MEM/WB instruction writes a register (rd != 0)
//   i_wb_rd     : MEM/WB destination register
//   o_fwd       : FWD_RF / FWD_EXMEM / FWD_MEMWB
module forward_select
  import pipeline_pkg::*;
(
  input  logic [3:0] i_src_reg,
  input  logic       i_mem_wr,
  input  logic       i_mem_is_ld,
  input  logic [3:0] i_mem_rd,
  input  logic       i_wb_wr,
  input  logic [3:0] i_wb_rd,
  output logic [1:0] o_fwd
);

  // EX/MEM is checked first so the youngest value wins on a double match
  always_comb begin
    o_fwd = FWD_RF;
    if (i_mem_wr && !i_mem_is_ld && (i_mem_rd == i_src_reg))
      o_fwd = FWD_EXMEM;
    else if (i_wb_wr && (i_wb_rd == i_src_reg))
      o_fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage in-order pipeline.
//   clock, reset        : single clock, async active-high reset
//   *_instruction       : instructions held in IF/ID, ID/EX, EX/MEM, MEM/WB
//   branch_taken        : EX resolved a taken branch/jump
//   mem_ready           : data memory finished the current access
//   pc_write, *_write   : stage load enables
//   *_flush             : stage loads a NOP / bubble
//   fwd_a, fwd_b        : ALU operand forwarding selects
//   stall_count         : saturating count of stall cycles
//   mem_timeout         : sticky flag, memory wait exceeded TIMEOUT_CYCLES
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] id_instruction,
  input  logic [INSTR_W-1:0] ex_instruction,
  input  logic [INSTR_W-1:0] mem_instruction,
  input  logic [INSTR_W-1:0] wb_instruction,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_flush,
  output logic               ex_mem_write,
  output logic               mem_wb_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [15:0]        stall_count,
  output logic               mem_timeout
);

  localparam logic [8:0] TO_CNT = 9'(TIMEOUT_CYCLES);

  hz_state_e   r_state, w_state_nxt;
  logic [8:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_timeout;

  logic        w_mem_busy, w_timed, w_freeze, w_load_use, w_lu_stall;
  logic [1:0]  w_fwd_a, w_fwd_b;
  logic        w_unused;

  assign w_mem_busy = (op_of(mem_instruction) inside {OP_LD, OP_ST}) && !mem_ready;
  // A timed-out wait is released exactly like a completed access
  assign w_timed    = (r_state == ST_MEM_WAIT) && (r_wait_cnt == TO_CNT);

  assign w_load_use = (op_of(ex_instruction) == OP_LD) && is_writer(ex_instruction) &&
                      ((reads_rs(id_instruction) && (rd_of(ex_instruction) == rs_of(id_instruction))) ||
                       (reads_rt(id_instruction) && (rd_of(ex_instruction) == rt_of(id_instruction))));

  // A taken branch squashes the dependent instruction, so no stall is needed
  assign w_lu_stall = !w_freeze && !branch_taken && w_load_use;

  assign w_unused = ^{id_instruction[3:0], ex_instruction[3:0], mem_instruction[11:0],
                      wb_instruction[11:0]};

  forward_select u_fwd_a (
    .i_src_reg   (rs_of(ex_instruction)),
    .i_mem_wr    (is_writer(mem_instruction)),
    .i_mem_is_ld (op_of(mem_instruction) == OP_LD),
    .i_mem_rd    (rd_of(mem_instruction)),
    .i_wb_wr     (is_writer(wb_instruction)),
    .i_wb_rd     (rd_of(wb_instruction)),
    .o_fwd       (w_fwd_a)
  );

  forward_select u_fwd_b (
    .i_src_reg   (rt_of(ex_instruction)),
    .i_mem_wr    (is_writer(mem_instruction)),
    .i_mem_is_ld (op_of(mem_instruction) == OP_LD),
    .i_mem_rd    (rd_of(mem_instruction)),
    .i_wb_wr     (is_writer(wb_instruction)),
    .i_wb_rd     (rd_of(wb_instruction)),
    .o_fwd       (w_fwd_b)
  );

  // Next state and freeze decision
  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_busy) begin
          w_freeze    = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready && !w_timed) w_freeze    = 1'b1;
        else                        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Control outputs; reset forces the pass-through pattern
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    if (!reset) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      if (w_freeze) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 9'd0;
      r_stall_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Held at zero in RUN, so it is always clear on entry to MEM_WAIT
      if (r_state == ST_RUN) r_wait_cnt <= 9'd0;
      else                   r_wait_cnt <= r_wait_cnt + 9'd1;
      if (w_timed) r_timeout <= 1'b1;
      if ((w_freeze || w_lu_stall) && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign mem_timeout = r_timeout;

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of MEM_WAIT cycles before mem_timeout is raised.
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
  clock  in  1  single clock; all state updates on posedge.
  reset  in  1  asynchronous, active-high reset.
  id_instruction  in  20  instruction in IF/ID.
  ex_instruction  in  20  instruction in ID/EX.
  mem_instruction  in  20  instruction in EX/MEM.
  wb_instruction  in  20  instruction in MEM/WB.
  branch_taken  in  1  EX-stage branch or jump resolved taken.
  mem_ready  in  1  data memory has completed the current access.
  pc_write  out  1  PC update enable.
  if_id_write  out  1  IF/ID load enable.
  if_id_flush  out  1  IF/ID loads a NOP.
  id_ex_write  out  1  ID/EX load enable.
  id_ex_flush  out  1  ID/EX loads a NOP.
  ex_mem_write  out  1  EX/MEM load enable.
  mem_wb_flush  out  1  MEM/WB loads a bubble.
  fwd_a  out  2  ALU operand A source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
  fwd_b  out  2  ALU operand B source, same encoding as fwd_a.
  stall_count  out  16  saturating count of stall cycles.
  mem_timeout  out  1  sticky memory-wait timeout flag.

Function
REQ-003 The instruction fields SHALL be: opcode [19:16], rd [15:12], rs [11:8], rt [7:4].
REQ-004 The opcodes SHALL be: NOP 4'h0, LD 4'h1, ST 4'h2, BEQ 4'h8, JMP 4'h9; every other opcode SHALL be treated as an ALU operation.
REQ-005 An instruction SHALL be classed as a register writer when its opcode is not ST, BEQ, JMP or NOP and its rd is not 0.
REQ-006 An instruction SHALL be classed as reading rs unless its opcode is NOP or JMP.
REQ-007 An instruction SHALL be classed as reading rt when its opcode is an ALU operation, ST or BEQ.
REQ-008 The FSM SHALL have states RUN and MEM_WAIT, and all control outputs SHALL be decoded combinationally from the state and the current inputs.
REQ-009 Memory busy is defined as: mem_instruction opcode is LD or ST and mem_ready = 0.
REQ-010 In RUN, memory busy SHALL hold pc_write = if_id_write = id_ex_write = ex_mem_write = 0, assert mem_wb_flush = 1 in the same cycle, and set the next state to MEM_WAIT.
REQ-011 In MEM_WAIT, the freeze of REQ-010 SHALL be held while mem_ready = 0.
REQ-012 In MEM_WAIT, the cycle with mem_ready = 1 SHALL release all enables and return the next state to RUN, with no extra bubble.
REQ-013 With memory not busy, branch_taken = 1 SHALL assert if_id_flush = id_ex_flush = 1 with pc_write = 1, flushing exactly 2 instructions.
REQ-014 Load-use is defined as: ex_instruction opcode is LD, it is a register writer, and its rd equals id_instruction rs (when rs is read) or rt (when rt is read).
REQ-015 Load-use SHALL set pc_write = if_id_write = 0 and id_ex_flush = 1 for exactly one cycle.
REQ-016 The priority SHALL be: memory busy > branch_taken > load-use; a branch taken in the same cycle as a load-use SHALL flush and SHALL NOT stall.
REQ-017 Forwarding for operand A SHALL give fwd_a = 10 when mem_instruction is a register writer, is not LD, and its rd equals ex_instruction rs.
REQ-018 Otherwise, fwd_a SHALL be 01 when wb_instruction is a register writer and its rd equals ex_instruction rs; otherwise fwd_a SHALL be 00.
REQ-019 fwd_b SHALL follow REQ-017 and REQ-018 using ex_instruction rt.
REQ-020 When the EX/MEM and MEM/WB stages both match, EX/MEM SHALL win.
REQ-021 stall_count SHALL increment by 1 in each cycle with a memory-busy freeze or a load-use stall, and SHALL saturate at 16'hFFFF.
REQ-022 A 9-bit wait counter SHALL clear on entry to MEM_WAIT and increment in each MEM_WAIT cycle.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES, mem_timeout SHALL be set and the wait counter SHALL release the freeze as if mem_ready = 1.
REQ-024 mem_timeout SHALL stay set until reset.

Reset
REQ-025 Asserting reset SHALL immediately put the state in RUN and clear stall_count, the wait counter and mem_timeout to 0, including when reset occurs mid-MEM_WAIT.
REQ-026 While reset = 1, the outputs SHALL be: all write enables = 1, all flushes = 0, fwd_a = fwd_b = 00.

Structure
REQ-027 The opcode constants, field bit positions, fwd_* encodings and FSM state encoding SHALL be placed in the shared package pipeline_pkg.
REQ-028 The forwarding comparison SHALL be implemented in a single sub-module, forward_select, instantiated once per operand.

Verification
REQ-029 LD r3 in EX with ADD r4,r3,r1 in ID -> one cycle with pc_write = 0 and id_ex_flush = 1, then fwd_a = 01 when the ADD reaches EX.
REQ-030 ADD r2 in EX/MEM and SUB r2 in MEM/WB, with ex rs = r2 -> fwd_a = 10.
REQ-031 LD in MEM with mem_ready low for 3 cycles -> 3 frozen cycles, then RUN, and stall_count = 3.
REQ-032 branch_taken together with a load-use -> if_id_flush = id_ex_flush = 1, pc_write = 1, and stall_count unchanged.
REQ-033 mem_ready held low with TIMEOUT_CYCLES = 4 -> mem_timeout = 1 after 4 wait cycles and the freeze released; a subsequent reset -> mem_timeout = 0.
REQ-034 Reset asserted in MEM_WAIT -> state RUN and all enables = 1 in the same cycle.
